uart_trx: RTL and testbench

Parametrised full-duplex UART transceiver. It replaces the fixed 8N1 echo-style transceiver used by the board top levels.
- Adds configurable baud rate, word length, parity and stop bits.
- Adds an oversampled, majority-voted receiver with false-start rejection and framing/parity error reporting.
- Uses a valid/ready handshake on the transmit side.
- Sits between board pins (txd/rxd) and the user logic in the top module.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_trx_if.sv | 24 ++
 rtl/uart_rx_core.sv | 158 +++++++++++++++
 rtl/uart_trx.sv | 137 +++++++++++++
 tb/tb_uart_trx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and timing helper for the uart_trx transceiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop, RxWaitHi} rx_state_e;

    // Clocks per oversampling tick, rounded to nearest and never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        logic [63:0] den;
        logic [63:0] div;
        den = 64'(baud) * 64'(ovs);
        div = (64'(clk_hz) + den / 64'd2) / den;
        return (div == 64'd0) ? 32'd1 : 32'(div);
    endfunction

endpackage

// File: rtl/uart_trx_if.sv
// User-side transmit handshake and receive strobe bundle for uart_trx.
interface uart_trx_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_err_parity;
    logic                 rx_err_frame;
    logic                 rx_busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, rx_data, rx_valid, rx_err_parity, rx_err_frame, rx_busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, rx_data, rx_valid, rx_err_parity, rx_err_frame, rx_busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchroniser, tick divider, 2-of-3 majority sampler and frame FSM.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DIV       = 4,
    parameter int unsigned OVS       = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 rx_err_parity_o,
    output logic                 rx_err_frame_o,
    output logic                 rx_busy_o
);
    localparam int unsigned DivW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OvsW    = $clog2(OVS);
    localparam int unsigned BitW    = $clog2(DATA_BITS + 1);
    localparam parity_e     ParMode = parity_e'(PARITY[1:0]);

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q;
    logic [DivW-1:0]      div_q, div_d;
    logic [OvsW-1:0]      ovs_q, ovs_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, eperr_q, eperr_d, eferr_q, eferr_d;

    logic rxs, counting, tick, dec, maj;

    assign rxs      = sync_q[1];
    assign counting = state_q inside {RxStart, RxData, RxPar, RxStop};
    assign tick     = counting && (div_q == DivW'(DIV - 1));
    // Decision lands on the third of the three mid-bit ticks.
    assign dec      = tick && (ovs_q == OvsW'(OVS / 2));
    assign maj      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ovs_d   = ovs_q;
        vote_d  = vote_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        eperr_d = eperr_q;
        eferr_d = eferr_q;

        if (counting) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                ovs_d = (ovs_q == OvsW'(OVS - 1)) ? '0 : ovs_q + 1'b1;
                if (ovs_q == OvsW'(OVS / 2 - 2)) vote_d[0] = rxs;
                if (ovs_q == OvsW'(OVS / 2 - 1)) vote_d[1] = rxs;
            end
        end

        unique case (state_q)
            RxIdle: begin
                if (!rxs) begin
                    state_d = RxStart;
                    div_d   = '0;
                    ovs_d   = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            RxStart: begin
                if (dec) state_d = maj ? RxIdle : RxData;
            end
            RxData: begin
                if (dec) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (ParMode == PAR_NONE) ? RxStop : RxPar;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            RxPar: begin
                if (dec) begin
                    perr_d  = maj ^ (^shift_q) ^ (ParMode == PAR_ODD);
                    state_d = RxStop;
                end
            end
            RxStop: begin
                if (dec) begin
                    if (bit_q == BitW'(STOP_BITS - 1)) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        eperr_d = perr_q;
                        eferr_d = ferr_q | ~maj;
                        state_d = maj ? RxIdle : RxWaitHi;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        ferr_d = ferr_q | ~maj;
                    end
                end
            end
            RxWaitHi: begin
                if (rxs) state_d = RxIdle;
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RxIdle;
            sync_q  <= 2'b11;
            div_q   <= '0;
            ovs_q   <= '0;
            vote_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            eperr_q <= 1'b0;
            eferr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rxd_i};
            div_q   <= div_d;
            ovs_q   <= ovs_d;
            vote_q  <= vote_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            eperr_q <= eperr_d;
            eferr_q <= eferr_d;
        end
    end

    assign rx_data_o       = data_q;
    assign rx_valid_o      = valid_q;
    assign rx_err_parity_o = eperr_q;
    assign rx_err_frame_o  = eferr_q;
    assign rx_busy_o       = (state_q != RxIdle);

endmodule

// File: rtl/uart_trx.sv
// Full-duplex UART transceiver: transmit FSM here, receiver in uart_rx_core.
module uart_trx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 24000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned OVS       = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic rxd,
    output logic txd,
    uart_trx_if.slave u_if
);
    localparam int unsigned Div     = calc_div(CLK_HZ, BAUD, OVS);
    localparam int unsigned BitClks = Div * OVS;
    localparam int unsigned CntW    = $clog2(BitClks);
    localparam int unsigned BitW    = $clog2(DATA_BITS + 1);
    localparam parity_e     ParMode = parity_e'(PARITY[1:0]);

    tx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 bit_end;

    assign bit_end = (cnt_q == CntW'(BitClks - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;

        if (state_q != TxIdle) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        unique case (state_q)
            TxIdle: begin
                txd_d = 1'b1;
                if (u_if.tx_valid) begin
                    // Start bit goes out on the same edge that drops tx_ready.
                    state_d = TxStart;
                    shift_d = u_if.tx_data;
                    par_d   = (^u_if.tx_data) ^ (ParMode == PAR_ODD);
                    txd_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            TxStart: begin
                if (bit_end) begin
                    state_d = TxData;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            TxData: begin
                if (bit_end) begin
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (ParMode == PAR_NONE) begin
                            state_d = TxStop;
                            txd_d   = 1'b1;
                        end else begin
                            state_d = TxPar;
                            txd_d   = par_q;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            TxPar: begin
                if (bit_end) begin
                    state_d = TxStop;
                    txd_d   = 1'b1;
                end
            end
            TxStop: begin
                if (bit_end) begin
                    if (bit_q == BitW'(STOP_BITS - 1)) state_d = TxIdle;
                    else bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    assign txd           = txd_q;
    assign u_if.tx_ready = (state_q == TxIdle);
    assign u_if.tx_busy  = (state_q != TxIdle);

    uart_rx_core #(
        .DIV       (Div),
        .OVS       (OVS),
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY),
        .STOP_BITS (STOP_BITS)
    ) u_rx (
        .clk_i           (sys_clk),
        .rst_i           (sys_rst),
        .rxd_i           (rxd),
        .rx_data_o       (u_if.rx_data),
        .rx_valid_o      (u_if.rx_valid),
        .rx_err_parity_o (u_if.rx_err_parity),
        .rx_err_frame_o  (u_if.rx_err_frame),
        .rx_busy_o       (u_if.rx_busy)
    );

endmodule

// File: tb/tb_uart_trx.sv
// Scoreboard bench for uart_trx: an 8N1 instance and an even-parity, two-stop instance.
`timescale 1ns/1ps
module tb_uart_trx;
    localparam int unsigned CLK_HZ   = 6400000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned OVS      = 16;
    localparam int unsigned BIT_CLKS = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic rxd_a, rxd_b_drv, rxd_b, txd_a, txd_b, loop_b;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int strobes_a = 0;
    int strobes_b = 0;
    int last_valid_a = 0;

    rx_exp_t exp_a[$];
    rx_exp_t exp_b[$];

    uart_trx_if #(.DATA_BITS(8)) if_a ();
    uart_trx_if #(.DATA_BITS(8)) if_b ();

    uart_trx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .sys_clk (clk),
        .sys_rst (rst_a),
        .rxd     (rxd_a),
        .txd     (txd_a),
        .u_if    (if_a)
    );

    uart_trx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .sys_clk (clk),
        .sys_rst (rst_b),
        .rxd     (rxd_b),
        .txd     (txd_b),
        .u_if    (if_b)
    );

    assign rxd_b = loop_b ? txd_b : rxd_b_drv;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic rx_exp_t mk(input logic [7:0] d, input logic p, input logic f);
        rx_exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        return e;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic chkr(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    endtask

    // Drives n line levels, LSB first, each one bit period long; call on a negedge.
    task automatic drive_bits(input logic sel_b, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_b) rxd_b_drv = bits[i];
            else rxd_a = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    // Offers one word to dut_b once it is ready; returns on the negedge after acceptance.
    task automatic tx_b(input logic [7:0] d);
        int w;
        w = 0;
        while (if_b.tx_ready !== 1'b1 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        chk1("tx_b_ready_in_time", w < 4000, 1'b1);
        if_b.tx_data  = d;
        if_b.tx_valid = 1'b1;
        @(negedge clk);
        if_b.tx_valid = 1'b0;
    endtask

    // Receive scoreboard monitors.
    initial forever begin
        rx_exp_t e;
        @(negedge clk);
        if (if_a.rx_valid === 1'b1) begin
            strobes_a++;
            last_valid_a = cyc;
            chk1("rx_a_expected", exp_a.size() != 0, 1'b1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                chkv("rx_a_data", 32'(if_a.rx_data), 32'(e.data));
                chk1("rx_a_perr", if_a.rx_err_parity, e.perr);
                chk1("rx_a_ferr", if_a.rx_err_frame, e.ferr);
            end
        end
    end

    initial forever begin
        rx_exp_t e;
        @(negedge clk);
        if (if_b.rx_valid === 1'b1) begin
            strobes_b++;
            chk1("rx_b_expected", exp_b.size() != 0, 1'b1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                chkv("rx_b_data", 32'(if_b.rx_data), 32'(e.data));
                chk1("rx_b_perr", if_b.rx_err_parity, e.perr);
                chk1("rx_b_ferr", if_b.rx_err_frame, e.ferr);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t0;
        int bad;
        int hs_bad;
        logic [9:0] fr;

        rst_a = 1'b1;
        rst_b = 1'b1;
        rxd_a = 1'b1;
        rxd_b_drv = 1'b1;
        loop_b = 1'b0;
        if_a.tx_valid = 1'b0;
        if_a.tx_data  = 8'h00;
        if_b.tx_valid = 1'b0;
        if_b.tx_data  = 8'h00;
        repeat (4) @(negedge clk);

        chk1("rst_txd", txd_a, 1'b1);
        chk1("rst_tx_ready", if_a.tx_ready, 1'b1);
        chk1("rst_tx_busy", if_a.tx_busy, 1'b0);
        chkv("rst_rx_data", 32'(if_a.rx_data), 0);
        chk1("rst_rx_valid", if_a.rx_valid, 1'b0);
        chk1("rst_rx_err_parity", if_a.rx_err_parity, 1'b0);
        chk1("rst_rx_err_frame", if_a.rx_err_frame, 1'b0);
        chk1("rst_rx_busy", if_a.rx_busy, 1'b0);
        chk1("rst_txd_b", txd_b, 1'b1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 transmit of 0xA5: start, LSB-first data, stop.
        fr = {1'b1, 8'hA5, 1'b0};
        if_a.tx_data  = 8'hA5;
        if_a.tx_valid = 1'b1;
        @(negedge clk);
        if_a.tx_valid = 1'b0;
        if_a.tx_data  = 8'h00;
        hs_bad = 0;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < BIT_CLKS; c++) begin
                if (txd_a !== fr[b]) bad++;
                if (if_a.tx_ready !== 1'b0 || if_a.tx_busy !== 1'b1) hs_bad++;
                @(negedge clk);
            end
            chkv($sformatf("tx_bit%0d_mismatched_cycles", b), bad, 0);
        end
        chkv("tx_ready_low_640_bad_cycles", hs_bad, 0);
        chk1("tx_ready_after_frame", if_a.tx_ready, 1'b1);
        chk1("tx_busy_after_frame", if_a.tx_busy, 1'b0);
        chk1("txd_idle_after_frame", txd_a, 1'b1);

        // 8N1 receive of 0x3C with strobe latency.
        repeat (20) @(negedge clk);
        t0 = cyc;
        exp_a.push_back(mk(8'h3C, 1'b0, 1'b0));
        drive_bits(1'b0, 16'({1'b1, 8'h3C, 1'b0}), 10);
        repeat (20) @(negedge clk);
        chkr("rx_latency_cycles", last_valid_a - t0, 600, 626);

        // Short low glitch is a false start.
        n0 = strobes_a;
        rxd_a = 1'b0;
        repeat (20) @(negedge clk);
        rxd_a = 1'b1;
        chk1("glitch_busy_seen", if_a.rx_busy, 1'b1);
        repeat (44) @(negedge clk);
        chk1("glitch_busy_cleared", if_a.rx_busy, 1'b0);
        repeat (100) @(negedge clk);
        chkv("glitch_strobes", strobes_a - n0, 0);

        // Stop bit low followed by a long break, then a clean frame.
        n0 = strobes_a;
        exp_a.push_back(mk(8'h81, 1'b0, 1'b1));
        drive_bits(1'b0, 16'({1'b0, 8'h81, 1'b0}), 10);
        repeat (200) @(negedge clk);
        chkv("break_strobes", strobes_a - n0, 1);
        rxd_a = 1'b1;
        repeat (100) @(negedge clk);
        exp_a.push_back(mk(8'h42, 1'b0, 1'b0));
        drive_bits(1'b0, 16'({1'b1, 8'h42, 1'b0}), 10);
        repeat (100) @(negedge clk);

        // Even parity: 0x07 needs parity bit 1.
        exp_b.push_back(mk(8'h07, 1'b1, 1'b0));
        drive_bits(1'b1, 16'({2'b11, 1'b0, 8'h07, 1'b0}), 12);
        repeat (50) @(negedge clk);
        exp_b.push_back(mk(8'h07, 1'b0, 1'b0));
        drive_bits(1'b1, 16'({2'b11, 1'b1, 8'h07, 1'b0}), 12);
        repeat (50) @(negedge clk);

        // Loopback, back-to-back words, then reset in the middle of a fourth.
        loop_b = 1'b1;
        repeat (10) @(negedge clk);
        n0 = strobes_b;
        exp_b.push_back(mk(8'h00, 1'b0, 1'b0));
        tx_b(8'h00);
        exp_b.push_back(mk(8'hFF, 1'b0, 1'b0));
        tx_b(8'hFF);
        exp_b.push_back(mk(8'h55, 1'b0, 1'b0));
        tx_b(8'h55);
        tx_b(8'h99);
        repeat (4 * BIT_CLKS + 20) @(negedge clk);
        chk1("mid_frame_tx_busy", if_b.tx_busy, 1'b1);
        chk1("mid_frame_rx_busy", if_b.rx_busy, 1'b1);
        rst_b = 1'b1;
        #1;
        chk1("reset_txd_high", txd_b, 1'b1);
        chk1("reset_tx_ready", if_b.tx_ready, 1'b1);
        chk1("reset_rx_busy", if_b.rx_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        repeat (300) @(negedge clk);
        chkv("loopback_strobes", strobes_b - n0, 3);
        exp_b.push_back(mk(8'h99, 1'b0, 1'b0));
        tx_b(8'h99);
        repeat (12 * BIT_CLKS + 100) @(negedge clk);

        chkv("exp_a_drained", 32'(exp_a.size()), 0);
        chkv("exp_b_drained", 32'(exp_b.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
